// File: rtl/pipe_reg.sv
// Parametrised pipeline register chain with a valid/ready handshake.
// Empty stages collapse bubbles, flush squashes all stages, and occupancy counts the valid stages.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OW = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid;
    logic [WIDTH-1:0]  data [STAGES];
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_valid;
    logic [WIDTH-1:0]  src_data [STAGES];

    // Ready chain, built from a running accumulator so no signal feeds back on itself.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = !valid[i] || acc;
            rdy[i] = acc;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OW'(valid[i]);
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];

    // Flush clears valid bits only; data is left in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush) begin
                    valid[i] <= 1'b0;
                end else if (rdy[i]) begin
                    valid[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data[i] <= src_data[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed self-checking bench for pipe_reg with WIDTH=32, STAGES=3, RESET_VAL=32'hDEADBEEF.
module tb_pipe_reg;

    localparam logic [31:0] RV = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flush;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    pipe_reg #(.WIDTH(32), .STAGES(3), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                       input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                       input logic [1:0] e_occ);
        vec_t v;
        v = '{iv, id, ordy, fl, e_ir, e_ov, e_od, e_occ};
        vecs.push_back(v);
    endtask

    // Drive inputs just after an edge, check in_ready, clock, then check registered outputs.
    task automatic step(input vec_t v, input int n);
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        flush     = v.fl;
        #1;
        chk($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(v.e_ir));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(v.e_ov));
        chk($sformatf("v%0d out_data", n), out_data, v.e_od);
        chk($sformatf("v%0d occupancy", n), 32'(occupancy), 32'(v.e_occ));
    endtask

    initial begin
        int cyc;
        //   iv  data ordy fl  ir  ov  od  occ
        // streaming
        add(1, 0, 1, 0, 1, 0, RV, 1);
        add(1, 1, 1, 0, 1, 0, RV, 2);
        add(1, 2, 1, 0, 1, 1, 0, 3);
        add(1, 3, 1, 0, 1, 1, 1, 3);
        add(1, 4, 1, 0, 1, 1, 2, 3);
        add(1, 5, 1, 0, 1, 1, 3, 3);
        add(0, 0, 1, 0, 1, 1, 4, 2);
        add(0, 0, 1, 0, 1, 1, 5, 1);
        add(0, 0, 1, 0, 1, 0, 5, 0);
        // backpressure, then pass-through on full
        add(1, 10, 0, 0, 1, 0, 5, 1);
        add(1, 11, 0, 0, 1, 0, 5, 2);
        add(1, 12, 0, 0, 1, 1, 10, 3);
        add(1, 13, 0, 0, 0, 1, 10, 3);
        add(1, 13, 1, 0, 1, 1, 11, 3);
        add(0, 0, 1, 0, 1, 1, 12, 2);
        add(0, 0, 1, 0, 1, 1, 13, 1);
        add(0, 0, 1, 0, 1, 0, 13, 0);
        // bubble collapse
        add(1, 7, 0, 0, 1, 0, 13, 1);
        add(0, 0, 0, 0, 1, 0, 13, 1);
        add(0, 0, 0, 0, 1, 1, 7, 1);
        add(1, 8, 0, 0, 1, 1, 7, 2);
        add(0, 0, 0, 0, 1, 1, 7, 2);
        add(0, 0, 1, 0, 1, 1, 8, 1);
        add(0, 0, 1, 0, 1, 0, 8, 0);
        // flush with a word offered on the same cycle
        add(1, 20, 0, 0, 1, 0, 8, 1);
        add(1, 21, 0, 0, 1, 0, 8, 2);
        add(1, 22, 0, 0, 1, 1, 20, 3);
        add(1, 99, 0, 1, 0, 0, 20, 0);
        add(0, 0, 1, 0, 1, 0, 20, 0);
        add(0, 0, 1, 0, 1, 0, 20, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", out_data, RV);
        chk("rst occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // async reset mid-stream with two words held
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'(30 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ar pre occupancy", 32'(occupancy), 32'd2);
        chk("ar pre out_data", out_data, 32'd31);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", 32'(out_valid), 32'd0);
        chk("ar occupancy", 32'(occupancy), 32'd0);
        chk("ar out_data", out_data, RV);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 32'd55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("ar relaunch latency", 32'(cyc), 32'd2);
        chk("ar relaunch out_data", out_data, 32'd55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
